hc165_reader: RTL

Serial input-expander reader for one or more daisy-chained 74HC165 parallel-in/serial-out shift registers. It generates the SH/LD and CLK pins, samples QH, and presents the captured bits as a parallel word with a one-cycle valid strobe and a change flag. It is the input-side counterpart of the 74HC595 segment-display driver and sits beside it at top level. It feeds key/switch banks into the design without spending one FPGA pin per input.

---
 rtl/hc165_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/hc165_reader.sv
// hc165_reader: scans a daisy-chain of 74HC165 PISO shift registers and
// presents the captured bits as a parallel word.
//
// Parameters
//   WIDTH     total bits in the chain (8 per chip), >= 1
//   CLK_DIV   serial half-period in clk cycles, >= 3 (covers the synchroniser)
//   SCAN_GAP  idle clk cycles between scans, may be 0
// Ports
//   clk, rst_n          system clock, async active-low reset
//   scan_en             level; scans repeat while high
//   sdi_in              QH of the last chip in the chain (asynchronous)
//   ld_n_out, sclk_out  SH/LD and CLK pins to the chain
//   data_out            last completed scan, first sampled bit in [WIDTH-1]
//   data_valid          one-cycle pulse when data_out updates
//   changed             coincident with data_valid when the word differs
//   busy                high from LOAD through DONE
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | pins parked, waiting for scan_en
// LOAD   | SH/LD low, chips latch their parallel inputs
// SETTLE | SH/LD high, MSB settles on QH before the first clock
// SHIFT  | WIDTH serial bits, each a low phase (sample) and a high phase
// DONE   | publish capture register, pulse data_valid / changed
// GAP    | idle spacing before the next scan
module hc165_reader #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int SCAN_GAP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             sdi_in,
  output logic             ld_n_out,
  output logic             sclk_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             changed,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic             phase_q, phase_d;   // 0: sclk low phase, 1: high phase
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sdi_meta_q, sdi_sync_q;
  logic             ld_n_q, ld_n_d;
  logic             sclk_q, sclk_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             busy_q, busy_d;
  logic             div_tc;

  assign div_tc = (div_q == '0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    cap_d   = cap_q;

    case (state_q)
      ST_IDLE: begin
        if (scan_en) begin
          state_d = ST_LOAD;
          div_d   = DIV_INIT;
        end
      end
      ST_LOAD: begin
        if (div_tc) begin
          state_d = ST_SETTLE;
          div_d   = DIV_INIT;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (div_tc) begin
          state_d = ST_SHIFT;
          div_d   = DIV_INIT;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_tc) begin
          div_d = DIV_INIT;
          if (!phase_q) begin
            // Sample at the end of the low phase, before the rising edge
            // that advances the chain.
            cap_d   = (cap_q << 1) | WIDTH'(sdi_sync_q);
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_DONE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (SCAN_GAP == 0) begin
          state_d = scan_en ? ST_LOAD : ST_IDLE;
          div_d   = DIV_INIT;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_INIT;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = scan_en ? ST_LOAD : ST_IDLE;
          div_d   = DIV_INIT;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins and flags are registered decodes of the current state, so they
  // trail the state register by one cycle.
  always_comb begin
    ld_n_d    = (state_q != ST_LOAD);
    sclk_d    = (state_q == ST_SHIFT) && phase_q;
    busy_d    = (state_q == ST_LOAD) || (state_q == ST_SETTLE) ||
                (state_q == ST_SHIFT) || (state_q == ST_DONE);
    valid_d   = (state_q == ST_DONE);
    changed_d = (state_q == ST_DONE) && (cap_q != data_q);
    data_d    = (state_q == ST_DONE) ? cap_q : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      cap_q      <= '0;
      data_q     <= '0;
      sdi_meta_q <= 1'b0;
      sdi_sync_q <= 1'b0;
      ld_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      cap_q      <= cap_d;
      data_q     <= data_d;
      sdi_meta_q <= sdi_in;
      sdi_sync_q <= sdi_meta_q;
      ld_n_q     <= ld_n_d;
      sclk_q     <= sclk_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      busy_q     <= busy_d;
    end
  end

  assign ld_n_out   = ld_n_q;
  assign sclk_out   = sclk_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign changed    = changed_q;
  assign busy       = busy_q;

endmodule
